rf_read_sequencer: RTL

Sequences operand reads from a single-read-port register file (one-cycle synchronous read latency, read-before-write on same-address collision) on behalf of decode. It accepts one instruction's source-register request, issues zero, one or two port reads, and snoops writeback so held operands are never stale. It then presents both operands to execute with a valid/ready handshake. Decode stalls whenever `req_ready` is low.

---
 rtl/rf_read_sequencer_if.sv | 36 +++
 rtl/rf_read_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rf_read_sequencer_if.sv
// Decode / register-file / writeback / execute signals around the operand read sequencer.
// The slave view belongs to the sequencer; the master view belongs to its surroundings.
interface rf_read_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [REG_W-1:0] rs1_addr;
  logic [REG_W-1:0] rs2_addr;
  logic             rs1_rden;
  logic             rs2_rden;
  logic             rf_rd_en;
  logic [REG_W-1:0] rf_rd_addr;
  logic [XLEN-1:0]  rf_rd_data;
  logic             wb_en;
  logic [REG_W-1:0] wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             op_valid;
  logic             op_ready;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             stall;

  modport slave (
    input  req_valid, rs1_addr, rs2_addr, rs1_rden, rs2_rden,
    input  rf_rd_data, wb_en, wb_addr, wb_data, op_ready,
    output req_ready, rf_rd_en, rf_rd_addr, op_valid, rs1_data, rs2_data, stall
  );

  modport master (
    output req_valid, rs1_addr, rs2_addr, rs1_rden, rs2_rden,
    output rf_rd_data, wb_en, wb_addr, wb_data, op_ready,
    input  req_ready, rf_rd_en, rf_rd_addr, op_valid, rs1_data, rs2_data, stall
  );
endinterface

// File: rtl/rf_read_sequencer.sv
// Issues up to two reads on a single-port register file for one decoded instruction,
// keeps the captured operands coherent with writeback, and hands them to execute.
module rf_read_sequencer #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_read_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RS1, RS2, OUT} state_t;

  state_t           state_q, state_d;
  logic [REG_W-1:0] a1_q, a2_q;
  logic             need1_q, need2_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  logic             byp_vld_p1;
  logic [XLEN-1:0]  byp_data_p1;

  logic             need1_in, need2_in, accept;
  logic             req_ready_c, rd_en_c;
  logic [REG_W-1:0] rd_addr_c;
  logic             hit1, hit2;

  // Captured value: same-cycle writeback beats the issue-cycle bypass, which beats the RF.
  function automatic logic [XLEN-1:0] cap_sel(input logic            hit,
                                              input logic            byp_vld,
                                              input logic [XLEN-1:0] byp_data,
                                              input logic [XLEN-1:0] wb_data,
                                              input logic [XLEN-1:0] rd_data);
    if (hit)          return wb_data;
    else if (byp_vld) return byp_data;
    else              return rd_data;
  endfunction

  assign need1_in = bus.rs1_rden && (bus.rs1_addr != '0);
  assign need2_in = bus.rs2_rden && (bus.rs2_addr != '0);
  assign accept   = bus.req_valid && req_ready_c;
  assign hit1     = bus.wb_en && need1_q && (bus.wb_addr == a1_q);
  assign hit2     = bus.wb_en && need2_q && (bus.wb_addr == a2_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = need1_in ? RS1 : (need2_in ? RS2 : OUT);
      RS1:     state_d = need2_q ? RS2 : OUT;
      RS2:     state_d = OUT;
      OUT:     if (bus.op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_c = (state_q == IDLE) && !rst;
    rd_en_c     = 1'b0;
    rd_addr_c   = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && need1_in) begin
            rd_en_c   = 1'b1;
            rd_addr_c = bus.rs1_addr;
          end else if (bus.req_valid && need2_in) begin
            rd_en_c   = 1'b1;
            rd_addr_c = bus.rs2_addr;
          end
        end
        RS1: begin
          if (need2_q) begin
            rd_en_c   = 1'b1;
            rd_addr_c = a2_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rf_rd_en   = rd_en_c;
  assign bus.rf_rd_addr = rd_addr_c;
  assign bus.op_valid   = (state_q == OUT);
  assign bus.rs1_data   = rs1_q;
  assign bus.rs2_data   = rs2_q;
  assign bus.stall      = bus.req_valid && !req_ready_c;

  // ---- issue stage (p0) -> capture stage (p1) ----
  always_ff @(posedge clk) begin
    byp_data_p1 <= bus.wb_data;
    if (accept) begin
      a1_q <= bus.rs1_addr;
      a2_q <= bus.rs2_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      need1_q    <= 1'b0;
      need2_q    <= 1'b0;
      byp_vld_p1 <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      // The RF returns the pre-write value when a read and a write to it share a cycle.
      byp_vld_p1 <= rd_en_c && bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rd_addr_c);
      case (state_q)
        IDLE: begin
          if (accept) begin
            need1_q <= need1_in;
            need2_q <= need2_in;
            rs1_q   <= '0;
            rs2_q   <= '0;
          end
        end
        RS1: rs1_q <= cap_sel(hit1, byp_vld_p1, byp_data_p1, bus.wb_data, bus.rf_rd_data);
        RS2: begin
          rs2_q <= cap_sel(hit2, byp_vld_p1, byp_data_p1, bus.wb_data, bus.rf_rd_data);
          if (hit1) rs1_q <= bus.wb_data;
        end
        OUT: begin
          if (!bus.op_ready) begin
            if (hit1) rs1_q <= bus.wb_data;
            if (hit2) rs2_q <= bus.wb_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
